// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module : mips_pkg
// Brief  : Opcode/funct encodings and control-vector bit positions for decode.
// Rev    : 1.0
// ============================================================================
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_JR = 6'h08;

    localparam int CTRL_W          = 10;
    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_REG_DST    = 1;
    localparam int CTRL_ALU_SRC    = 2;
    localparam int CTRL_MEM_READ   = 3;
    localparam int CTRL_MEM_WRITE  = 4;
    localparam int CTRL_MEM_TO_REG = 5;
    localparam int CTRL_BRANCH_EQ  = 6;
    localparam int CTRL_BRANCH_NE  = 7;
    localparam int CTRL_JUMP       = 8;
    localparam int CTRL_LINK       = 9;

    typedef logic [CTRL_W-1:0] ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mips_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module : mips_ctrl_decode
// Brief  : Combinational opcode/funct decode to control vector, sext, illegal.
// Rev    : 1.0
// ============================================================================
module mips_ctrl_decode
    import mips_pkg::*;
#(
    parameter int ILLEGAL_AS_NOP = 1
) (
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output ctrl_t      o_ctrl,
    output logic       o_sext,
    output logic       o_illegal
);

    ctrl_t w_ctrl;
    logic  w_sext;
    logic  w_illegal;

    always_comb begin
        w_ctrl    = '0;
        w_sext    = 1'b0;
        w_illegal = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                w_ctrl[CTRL_REG_DST] = 1'b1;
                if (i_funct == FUNCT_JR) w_ctrl[CTRL_JUMP]      = 1'b1;
                else                     w_ctrl[CTRL_REG_WRITE] = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                w_ctrl[CTRL_ALU_SRC]   = 1'b1;
                w_ctrl[CTRL_REG_WRITE] = 1'b1;
                w_sext                 = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                w_ctrl[CTRL_ALU_SRC]   = 1'b1;
                w_ctrl[CTRL_REG_WRITE] = 1'b1;
            end
            OP_LW: begin
                w_ctrl[CTRL_ALU_SRC]    = 1'b1;
                w_ctrl[CTRL_MEM_READ]   = 1'b1;
                w_ctrl[CTRL_MEM_TO_REG] = 1'b1;
                w_ctrl[CTRL_REG_WRITE]  = 1'b1;
                w_sext                  = 1'b1;
            end
            OP_SW: begin
                w_ctrl[CTRL_ALU_SRC]   = 1'b1;
                w_ctrl[CTRL_MEM_WRITE] = 1'b1;
                w_sext                 = 1'b1;
            end
            OP_BEQ: begin
                w_ctrl[CTRL_BRANCH_EQ] = 1'b1;
                w_sext                 = 1'b1;
            end
            OP_BNE: begin
                w_ctrl[CTRL_BRANCH_NE] = 1'b1;
                w_sext                 = 1'b1;
            end
            OP_J:   w_ctrl[CTRL_JUMP] = 1'b1;
            OP_JAL: begin
                w_ctrl[CTRL_JUMP]      = 1'b1;
                w_ctrl[CTRL_LINK]      = 1'b1;
                w_ctrl[CTRL_REG_WRITE] = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Undefined opcodes decode to all-zero control regardless; the mask keeps that explicit.
    assign o_ctrl    = ((ILLEGAL_AS_NOP != 0) && w_illegal) ? '0 : w_ctrl;
    assign o_sext    = w_sext;
    assign o_illegal = w_illegal;

endmodule
`default_nettype wire

// File: rtl/id_stage_reg.sv
`default_nettype none
// ============================================================================
// Module : id_stage_reg
// Brief  : IF->ID pipeline register with valid/ready handshake, flush and decode.
// Rev    : 1.0
// ============================================================================
module id_stage_reg
    import mips_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ILLEGAL_AS_NOP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc4,
    output logic            id_ready,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc4,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      shamt,
    output logic [5:0]      funct,
    output logic [15:0]     imm,
    output logic            sext,
    output logic [25:0]     jtarget,
    output logic            reg_write,
    output logic            reg_dst,
    output logic            alu_src,
    output logic            mem_read,
    output logic            mem_write,
    output logic            mem_to_reg,
    output logic            branch_eq,
    output logic            branch_ne,
    output logic            jump,
    output logic            link,
    output logic            illegal
);

    logic            r_valid;
    logic [25:0]     r_instr;
    logic [XLEN-1:0] r_pc4;
    ctrl_t           r_ctrl;
    logic            r_sext;
    logic            r_illegal;

    ctrl_t           w_ctrl;
    logic            w_sext;
    logic            w_illegal;
    logic            w_load;

    mips_ctrl_decode #(
        .ILLEGAL_AS_NOP (ILLEGAL_AS_NOP)
    ) u_decode (
        .i_opcode  (if_instr[31:26]),
        .i_funct   (if_instr[5:0]),
        .o_ctrl    (w_ctrl),
        .o_sext    (w_sext),
        .o_illegal (w_illegal)
    );

    assign id_ready = !r_valid || ex_ready;
    assign w_load   = if_valid && id_ready && !flush;

    // Flush only clears valid; payload registers keep their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_instr   <= '0;
            r_pc4     <= '0;
            r_ctrl    <= '0;
            r_sext    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_valid   <= 1'b0;
        end else if (w_load) begin
            r_valid   <= 1'b1;
            r_instr   <= if_instr[25:0];
            r_pc4     <= if_pc4;
            r_ctrl    <= w_ctrl;
            r_sext    <= w_sext;
            r_illegal <= w_illegal;
        end else if (ex_ready) begin
            r_valid   <= 1'b0;
        end
    end

    assign id_valid   = r_valid;
    assign id_pc4     = r_pc4;
    assign rs         = r_instr[25:21];
    assign rt         = r_instr[20:16];
    assign rd         = r_instr[15:11];
    assign shamt      = r_instr[10:6];
    assign funct      = r_instr[5:0];
    assign imm        = r_instr[15:0];
    assign jtarget    = r_instr[25:0];
    assign sext       = r_sext;
    assign illegal    = r_illegal;
    assign reg_write  = r_ctrl[CTRL_REG_WRITE];
    assign reg_dst    = r_ctrl[CTRL_REG_DST];
    assign alu_src    = r_ctrl[CTRL_ALU_SRC];
    assign mem_read   = r_ctrl[CTRL_MEM_READ];
    assign mem_write  = r_ctrl[CTRL_MEM_WRITE];
    assign mem_to_reg = r_ctrl[CTRL_MEM_TO_REG];
    assign branch_eq  = r_ctrl[CTRL_BRANCH_EQ];
    assign branch_ne  = r_ctrl[CTRL_BRANCH_NE];
    assign jump       = r_ctrl[CTRL_JUMP];
    assign link       = r_ctrl[CTRL_LINK];

endmodule
`default_nettype wire
